// File: rtl/tag_free_list_mp.sv
// Multi-port free list of physical/ROB tags.
// Free tags sit in a circular table between rp (oldest free) and wp (next
// return slot). Both pointers carry an extra wrap bit so count = wp - rp
// covers 0..NUM_TAGS without ambiguity. Reset and flush rebuild the
// identity table so every tag is free again.
module tag_free_list_mp #(
  parameter int NUM_TAGS  = 64,
  parameter int TAG_W     = 6,
  parameter int N_ALLOC   = 2,
  parameter int N_RET     = 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_ALLOC-1:0]       alloc_en,
  output logic [N_ALLOC*TAG_W-1:0] tag_out,
  output logic [N_ALLOC-1:0]       tag_avail,
  input  logic [N_RET-1:0]         ret_valid,
  input  logic [N_RET*TAG_W-1:0]   ret_tag,
  output logic [TAG_W:0]           count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     err_order,
  output logic                     err_ovf
);

  localparam int PTR_W = TAG_W + 1;
  localparam logic [PTR_W-1:0] NUM_TAGS_P = PTR_W'(NUM_TAGS);

  logic [TAG_W-1:0] entry [NUM_TAGS];
  logic [PTR_W-1:0] rp_reg, wp_reg, rp_next, wp_next;
  logic [PTR_W-1:0] grant_cnt, acc_cnt;
  logic [N_ALLOC-1:0] grant;
  logic [N_RET-1:0]   ret_acc;
  logic [TAG_W-1:0]   ret_idx [N_RET];
  logic               ovf_hit;
  logic               order_hit;

  assign count        = wp_reg - rp_reg;
  assign empty        = (count == '0);
  assign full         = (count == NUM_TAGS_P);
  assign almost_empty = (count <= PTR_W'(AE_THRESH));

  // Offer side: port k shows the k-th oldest free tag; port 1 is only
  // granted together with port 0 so grants always consume from the head.
  for (genvar gi = 0; gi < N_ALLOC; gi++) begin : g_offer
    logic [TAG_W-1:0] rd_idx;
    assign rd_idx = rp_reg[TAG_W-1:0] + TAG_W'(gi);
    assign tag_out[gi*TAG_W +: TAG_W] = entry[rd_idx];
    assign tag_avail[gi] = (count > PTR_W'(gi));
    assign grant[gi] = alloc_en[gi] & tag_avail[gi] & ((gi == 0) | alloc_en[0]);
  end

  if (N_ALLOC > 1) begin : g_order
    assign order_hit = alloc_en[N_ALLOC-1] & ~alloc_en[0];
  end else begin : g_no_order
    assign order_hit = 1'b0;
  end

  // Count grants, then accept returns in port order while room remains
  // after this cycle's grants; accepted returns pack densely from wp.
  always_comb begin
    grant_cnt = '0;
    for (int k = 0; k < N_ALLOC; k++) begin
      grant_cnt = grant_cnt + PTR_W'(grant[k]);
    end
    acc_cnt = '0;
    ovf_hit = 1'b0;
    for (int p = 0; p < N_RET; p++) begin
      ret_acc[p] = 1'b0;
      ret_idx[p] = wp_reg[TAG_W-1:0] + acc_cnt[TAG_W-1:0];
      if (ret_valid[p]) begin
        if ((count - grant_cnt + acc_cnt) < NUM_TAGS_P) begin
          ret_acc[p] = 1'b1;
          acc_cnt    = acc_cnt + PTR_W'(1);
        end else begin
          ovf_hit = 1'b1;
        end
      end
    end
    rp_next = rp_reg + grant_cnt;
    wp_next = wp_reg + acc_cnt;
  end

  // Pointer and sticky error state; flush restores pointers but keeps errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_reg    <= '0;
      wp_reg    <= NUM_TAGS_P;
      err_order <= 1'b0;
      err_ovf   <= 1'b0;
    end else if (flush) begin
      rp_reg <= '0;
      wp_reg <= NUM_TAGS_P;
    end else begin
      rp_reg <= rp_next;
      wp_reg <= wp_next;
      if (order_hit) err_order <= 1'b1;
      if (ovf_hit)   err_ovf   <= 1'b1;
    end
  end

  // One register per table slot so reset/flush can reload the identity map.
  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_slot
    logic [TAG_W-1:0] slot_reg, slot_next;

    // Pick up an accepted return aimed at this slot.
    always_comb begin
      slot_next = slot_reg;
      for (int p = 0; p < N_RET; p++) begin
        if (ret_acc[p] && (ret_idx[p] == TAG_W'(gi))) begin
          slot_next = ret_tag[p*TAG_W +: TAG_W];
        end
      end
    end

    // Slot storage: identity value on reset and flush.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_reg <= TAG_W'(gi);
      end else if (flush) begin
        slot_reg <= TAG_W'(gi);
      end else begin
        slot_reg <= slot_next;
      end
    end

    assign entry[gi] = slot_reg;
  end

endmodule

// File: tb/tb_tag_free_list_mp.sv
// Bench for tag_free_list_mp: directed scenarios plus a randomized run
// against a queue model of the free list (front = next tag offered).
module tb_tag_free_list_mp;

  localparam int NT = 64;
  localparam int TW = 6;

  logic           clk;
  logic           rst;
  logic           flush;
  logic [1:0]     alloc_en;
  logic [2*TW-1:0] tag_out;
  logic [1:0]     tag_avail;
  logic [1:0]     ret_valid;
  logic [2*TW-1:0] ret_tag;
  logic [TW:0]    count;
  logic           empty, full, almost_empty, err_order, err_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int q[$];
  bit m_order, m_ovf;

  tag_free_list_mp #(
    .NUM_TAGS(NT), .TAG_W(TW), .N_ALLOC(2), .N_RET(2), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_en(alloc_en), .tag_out(tag_out), .tag_avail(tag_avail),
    .ret_valid(ret_valid), .ret_tag(ret_tag),
    .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
    .err_order(err_order), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_fill();
    q.delete();
    for (int i = 0; i < NT; i++) q.push_back(i);
  endfunction

  function automatic void model_reset();
    model_fill();
    m_order = 1'b0;
    m_ovf   = 1'b0;
  endfunction

  // Free-list rules: flush refills; grants pop from the head (port 1 only
  // alongside port 0); returns append while the list has room.
  function automatic void model_step(input logic [1:0] a, input logic [1:0] rv,
                                     input logic [2*TW-1:0] rt, input logic fl);
    int g;
    if (fl) begin
      model_fill();
      return;
    end
    if (a[1] && !a[0]) m_order = 1'b1;
    g = 0;
    if (a[0] && q.size() > 0) g = 1;
    if (g == 1 && a[1] && q.size() > 1) g = 2;
    repeat (g) void'(q.pop_front());
    for (int p = 0; p < 2; p++) begin
      if (rv[p]) begin
        if (q.size() < NT) q.push_back(int'(rt[p*TW +: TW]));
        else m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic set_in(input logic [1:0] a, input logic [1:0] rv,
                        input logic [2*TW-1:0] rt, input logic fl);
    alloc_en  = a;
    ret_valid = rv;
    ret_tag   = rt;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    model_step(alloc_en, ret_valid, ret_tag, flush);
    cyc++;
    $display("cyc %0d alloc=%b ret=%b tags=%0d,%0d flush=%b count_before=%0d",
             cyc, alloc_en, ret_valid, ret_tag[TW +: TW], ret_tag[0 +: TW], flush, count);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(2'b00, 2'b00, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (count !== 7'd64) begin bad++; $display("FAIL reset_count got=%0d want=64", count); end
    total++; if (full !== 1'b1 || empty !== 1'b0 || almost_empty !== 1'b0) begin bad++; $display("FAIL reset_flags full=%b empty=%b ae=%b want 1 0 0", full, empty, almost_empty); end
    total++; if (tag_out[0 +: TW] !== 6'd0 || tag_out[TW +: TW] !== 6'd1) begin bad++; $display("FAIL reset_tags got=%0d,%0d want=0,1", tag_out[0 +: TW], tag_out[TW +: TW]); end
    total++; if (tag_avail !== 2'b11) begin bad++; $display("FAIL reset_avail got=%b want=11", tag_avail); end
    total++; if (err_order !== 1'b0 || err_ovf !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", err_order, err_ovf); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 31; i++) begin
      set_in(2'b11, 2'b00, '0, 1'b0);
      total++;
      if (tag_out[0 +: TW] !== 6'(2*i) || tag_out[TW +: TW] !== 6'(2*i+1) || tag_avail !== 2'b11) begin
        bad++; $display("FAIL drain_offer i=%0d got=%0d,%0d avail=%b want=%0d,%0d avail=11",
                        i, tag_out[0 +: TW], tag_out[TW +: TW], tag_avail, 2*i, 2*i+1);
      end
      tick();
    end
    total++; if (count !== 7'd2 || almost_empty !== 1'b1) begin bad++; $display("FAIL drain_count2 got=%0d ae=%b want=2 ae=1", count, almost_empty); end
    set_in(2'b01, 2'b00, '0, 1'b0);
    tick();
    set_in(2'b11, 2'b00, '0, 1'b0);
    total++; if (tag_avail !== 2'b01 || tag_out[0 +: TW] !== 6'd63) begin bad++; $display("FAIL last_tag avail=%b tag=%0d want avail=01 tag=63", tag_avail, tag_out[0 +: TW]); end
    tick();
    total++; if (count !== 7'd0 || empty !== 1'b1 || tag_avail !== 2'b00) begin bad++; $display("FAIL drained count=%0d empty=%b avail=%b want 0 1 00", count, empty, tag_avail); end
    set_in(2'b11, 2'b00, '0, 1'b0);
    tick();
    total++; if (count !== 7'd0 || err_order !== 1'b0) begin bad++; $display("FAIL alloc_on_empty count=%0d err_order=%b want 0 0", count, err_order); end
  endtask

  task automatic test_return_empty();
    set_in(2'b00, 2'b11, {6'd5, 6'd9}, 1'b0);
    total++; if (tag_avail !== 2'b00 || count !== 7'd0) begin bad++; $display("FAIL no_bypass avail=%b count=%0d want 00 0", tag_avail, count); end
    tick();
    set_in(2'b00, 2'b00, '0, 1'b0);
    total++; if (count !== 7'd2) begin bad++; $display("FAIL ret_count got=%0d want=2", count); end
    total++; if (tag_out[0 +: TW] !== 6'd9 || tag_out[TW +: TW] !== 6'd5) begin bad++; $display("FAIL ret_order got=%0d,%0d want=9,5", tag_out[0 +: TW], tag_out[TW +: TW]); end
  endtask

  task automatic test_flush();
    set_in(2'b10, 2'b00, '0, 1'b0);
    tick();
    total++; if (count !== 7'd2 || err_order !== 1'b1) begin bad++; $display("FAIL order count=%0d err_order=%b want 2 1", count, err_order); end
    for (int i = 0; i < 4; i++) begin
      set_in(2'b00, 2'b11, {6'(20+2*i), 6'(21+2*i)}, 1'b0);
      tick();
    end
    total++; if (count !== 7'd10) begin bad++; $display("FAIL preflush_count got=%0d want=10", count); end
    set_in(2'b11, 2'b01, {6'd0, 6'd33}, 1'b1);
    tick();
    set_in(2'b00, 2'b00, '0, 1'b0);
    total++; if (count !== 7'd64 || full !== 1'b1) begin bad++; $display("FAIL flush_count got=%0d full=%b want 64 1", count, full); end
    total++; if (tag_out[0 +: TW] !== 6'd0 || tag_out[TW +: TW] !== 6'd1) begin bad++; $display("FAIL flush_tags got=%0d,%0d want=0,1", tag_out[0 +: TW], tag_out[TW +: TW]); end
    total++; if (err_order !== 1'b1) begin bad++; $display("FAIL flush_err_order got=%b want=1", err_order); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 31; i++) begin
      set_in(2'b11, 2'b00, '0, 1'b0);
      tick();
    end
    set_in(2'b01, 2'b00, '0, 1'b0);
    tick();
    set_in(2'b01, 2'b10, {6'd7, 6'd0}, 1'b0);
    total++; if (tag_out[0 +: TW] !== 6'd63 || count !== 7'd1) begin bad++; $display("FAIL prewrap tag=%0d count=%0d want 63 1", tag_out[0 +: TW], count); end
    tick();
    set_in(2'b00, 2'b00, '0, 1'b0);
    total++; if (count !== 7'd1 || tag_avail !== 2'b01) begin bad++; $display("FAIL wrap_count got=%0d avail=%b want 1 01", count, tag_avail); end
    total++; if (tag_out[0 +: TW] !== 6'd7) begin bad++; $display("FAIL wrap_tag got=%0d want=7", tag_out[0 +: TW]); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    set_in(2'b01, 2'b01, {6'd0, 6'd42}, 1'b0);
    tick();
    total++; if (count !== 7'd64 || err_ovf !== 1'b0) begin bad++; $display("FAIL full_swap count=%0d err_ovf=%b want 64 0", count, err_ovf); end
    total++; if (tag_out[0 +: TW] !== 6'd1) begin bad++; $display("FAIL full_swap_head got=%0d want=1", tag_out[0 +: TW]); end
    set_in(2'b00, 2'b01, {6'd0, 6'd43}, 1'b0);
    tick();
    total++; if (count !== 7'd64 || err_ovf !== 1'b1) begin bad++; $display("FAIL ovf count=%0d err_ovf=%b want 64 1", count, err_ovf); end
    set_in(2'b11, 2'b00, '0, 1'b0);
    repeat (3) tick();
    total++; if (err_ovf !== 1'b1 || count !== 7'd58) begin bad++; $display("FAIL ovf_sticky err_ovf=%b count=%0d want 1 58", err_ovf, count); end
  endtask

  task automatic test_async_reset();
    set_in(2'b10, 2'b00, '0, 1'b0);
    tick();
    set_in(2'b11, 2'b00, '0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (count !== 7'd64 || full !== 1'b1 || tag_avail !== 2'b11) begin bad++; $display("FAIL async_count count=%0d full=%b avail=%b want 64 1 11", count, full, tag_avail); end
    total++; if (tag_out[0 +: TW] !== 6'd0 || tag_out[TW +: TW] !== 6'd1) begin bad++; $display("FAIL async_tags got=%0d,%0d want=0,1", tag_out[0 +: TW], tag_out[TW +: TW]); end
    total++; if (err_order !== 1'b0 || err_ovf !== 1'b0) begin bad++; $display("FAIL async_err got=%b%b want=00", err_order, err_ovf); end
    set_in(2'b00, 2'b00, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      set_in(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             {6'($urandom_range(0, NT-1)), 6'($urandom_range(0, NT-1))},
             ($urandom_range(0, 39) == 0));
      total++; if (int'(count) != q.size()) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, q.size()); end
      total++; if (empty !== (q.size() == 0) || full !== (q.size() == NT) || almost_empty !== (q.size() <= 2)) begin
        bad++; $display("FAIL rnd_flags n=%0d got=%b%b%b size=%0d", n, empty, full, almost_empty, q.size());
      end
      for (int k = 0; k < 2; k++) begin
        total++; if (tag_avail[k] !== (q.size() > k)) begin bad++; $display("FAIL rnd_avail n=%0d port=%0d got=%b size=%0d", n, k, tag_avail[k], q.size()); end
        if (q.size() > k) begin
          total++; if (int'(tag_out[k*TW +: TW]) != q[k]) begin bad++; $display("FAIL rnd_tag n=%0d port=%0d got=%0d want=%0d", n, k, tag_out[k*TW +: TW], q[k]); end
        end
      end
      tick();
      total++; if (err_order !== m_order || err_ovf !== m_ovf) begin bad++; $display("FAIL rnd_err n=%0d got=%b%b want=%b%b", n, err_order, err_ovf, m_order, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_return_empty();
    test_flush();
    test_wrap();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
